// File: rtl/sdr_rdata_fifo_pkg.sv
// Shared sizing defaults for the SDRAM read-data FIFO and its register-file storage.
package sdr_rdata_fifo_pkg;
    localparam int SDR_RDF_DW = 16;   // matches sdr_DQ
    localparam int SDR_RDF_AW = 4;    // 16 entries
    localparam int SDR_RDF_CW = 12;   // matches sdr_rd_byte_cnt
endpackage

// File: rtl/sdr_fifo_mem.sv
// DEPTH x DW register file: one synchronous write port, one asynchronous read port.
module sdr_fifo_mem #(
    parameter int DW = 16,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);
    localparam int DEPTH = 1 << AW;

    // Contents are don't-care after reset, so the array carries no reset.
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/sdr_rdata_fifo.sv
// Read-data buffer behind sdr_rd: FWFT host stream, free-space report, request word counting.
module sdr_rdata_fifo
    import sdr_rdata_fifo_pkg::*;
#(
    parameter int DW = SDR_RDF_DW,
    parameter int AW = SDR_RDF_AW,
    parameter int CW = SDR_RDF_CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sdr_rd_req,
    input  logic [CW-1:0] sdr_rd_byte_cnt,
    input  logic          sdr_rdata_wr,
    input  logic [DW-1:0] sdr_rdata,
    output logic [AW:0]   sdr_rdata_unfilled_depth,
    output logic          host_rdata_vld,
    output logic [DW-1:0] host_rdata,
    input  logic          host_rdata_rdy,
    output logic          host_rdata_last,
    output logic          rd_xfer_done,
    output logic [AW:0]   fill_cnt,
    output logic          ovf_err
);
    localparam int            DEPTH   = 1 << AW;
    localparam logic [AW:0]   DEPTH_V = (AW+1)'(DEPTH);
    localparam logic [AW:0]   FILL_1  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_1   = AW'(1);
    localparam logic [CW-1:0] REM_0   = '0;
    localparam logic [CW-1:0] REM_1   = CW'(1);

    logic [AW-1:0] wptr, rptr;
    logic [CW-1:0] remaining;
    logic          push, pop;

    assign pop  = host_rdata_vld & host_rdata_rdy;
    // Full still accepts a push when the head leaves in the same cycle.
    assign push = sdr_rdata_wr & ((fill_cnt < DEPTH_V) | pop);

    assign host_rdata_vld           = (fill_cnt != '0);
    assign host_rdata_last          = host_rdata_vld & (remaining == REM_1);
    assign sdr_rdata_unfilled_depth = DEPTH_V - fill_cnt;

    sdr_fifo_mem #(.DW(DW), .AW(AW)) u_mem (
        .clk     (clk),
        .wr_en   (push & ~sdr_rd_req),
        .wr_addr (wptr),
        .wr_data (sdr_rdata),
        .rd_addr (rptr),
        .rd_data (host_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr         <= '0;
            rptr         <= '0;
            fill_cnt     <= '0;
            remaining    <= '0;
            ovf_err      <= 1'b0;
            rd_xfer_done <= 1'b0;
        end else if (sdr_rd_req) begin
            // Flush wins: any push or pop in this cycle is discarded.
            wptr         <= '0;
            rptr         <= '0;
            fill_cnt     <= '0;
            remaining    <= sdr_rd_byte_cnt;
            ovf_err      <= 1'b0;
            rd_xfer_done <= 1'b0;
        end else begin
            if (push) wptr <= wptr + PTR_1;
            if (pop)  rptr <= rptr + PTR_1;
            case ({push, pop})
                2'b10:   fill_cnt <= fill_cnt + FILL_1;
                2'b01:   fill_cnt <= fill_cnt - FILL_1;
                default: fill_cnt <= fill_cnt;
            endcase
            if (sdr_rdata_wr & ~push) ovf_err <= 1'b1;
            // Surplus words popped at zero leave the count alone.
            if (pop && remaining != REM_0) remaining <= remaining - REM_1;
            rd_xfer_done <= pop & (remaining == REM_1);
        end
    end
endmodule
